// File: rtl/nios_system_pio_pkg.sv
// rtl/nios_system_pio_pkg.sv - register map and edge-type constants for the switch PIO
package nios_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_system_pio_debounce.sv
// rtl/nios_system_pio_debounce.sv - single-bit synchroniser with optional debounce filter
module nios_system_pio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable = sync_bit;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            // The edge on which the count would reach DEBOUNCE_CYCLES is the
            // one that accepts the new value, so the filter adds exactly
            // DEBOUNCE_CYCLES edges of latency.
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          stable_q;

            // Count consecutive disagreeing cycles; accept the new level once enough have passed
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt      <= '0;
                    stable_q <= 1'b0;
                end else if (sync_bit == stable_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable_q <= sync_bit;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign stable = stable_q;
        end
    endgenerate

endmodule

// File: rtl/nios_system_switch_pio_irq.sv
// rtl/nios_system_switch_pio_irq.sv - Avalon-MM input PIO with edge capture and maskable IRQ
module nios_system_switch_pio_irq
    import nios_system_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign unused_writedata = ^writedata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            nios_system_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .in_bit  (in_port[gi]),
                .stable  (stable[gi])
            );
        end
    endgenerate

    // Select which transitions of the debounced value count as events
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_det = stable & ~prev;
            EDGE_FALLING: edge_det = ~stable & prev;
            default:      edge_det = stable ^ prev;
        endcase
    end

    // Bits the CPU asks to clear this cycle via write-1-to-clear
    always_comb begin
        clear_bits = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
            clear_bits = writedata[WIDTH-1:0];
        end
    end

    // Track previous value, capture edges (set beats clear) and hold the interrupt mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= '0;
            edgecapture <= '0;
            irqmask     <= '0;
        end else begin
            prev        <= stable;
            edgecapture <= (edgecapture & ~clear_bits) | edge_det;
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Read mux; unused upper bits stay zero
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
            default:      rd_next = '0;
        endcase
    end

    // Register read data every cycle for single-cycle read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios_system_switch_pio_irq.sv
// tb/tb_nios_system_switch_pio_irq.sv - self-checking bench for the switch PIO
module tb_nios_system_switch_pio_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs0, cs1, cs2;
    logic [7:0]  in0, in1, in2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  in_val;
        logic [1:0]  addr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vec [11];

    always #5 clk = ~clk;

    nios_system_switch_pio_irq #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)
    ) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0)
    );

    nios_system_switch_pio_irq #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
    ) dut_db (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1)
    );

    nios_system_switch_pio_irq #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
    ) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rd_of(input int sel);
        case (sel)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
        cs0       = (sel == 0);
        cs1       = (sel == 1);
        cs2       = (sel == 2);
        write_n   = 1'b0;
        address   = a;
        writedata = d;
        @(negedge clk);
        cs0       = 1'b0;
        cs1       = 1'b0;
        cs2       = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
    endtask

    task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        @(negedge clk);
        chk(name, rd_of(sel), exp);
    endtask

    initial begin
        vec[0]  = '{8'hA5, 2'd0, 32'h00, 1'b0};
        vec[1]  = '{8'hA5, 2'd0, 32'h00, 1'b0};
        vec[2]  = '{8'hA5, 2'd0, 32'hA5, 1'b1};
        vec[3]  = '{8'hA5, 2'd2, 32'h0F, 1'b1};
        vec[4]  = '{8'hA5, 2'd3, 32'hA5, 1'b1};
        vec[5]  = '{8'hA5, 2'd1, 32'h00, 1'b1};
        vec[6]  = '{8'hFF, 2'd3, 32'hA5, 1'b1};
        vec[7]  = '{8'hFF, 2'd3, 32'hA5, 1'b1};
        vec[8]  = '{8'hFF, 2'd3, 32'hA5, 1'b1};
        vec[9]  = '{8'hFF, 2'd3, 32'hFF, 1'b1};
        vec[10] = '{8'hFF, 2'd0, 32'hFF, 1'b1};

        reset_n   = 1'b0;
        address   = 2'd0;
        write_n   = 1'b1;
        writedata = '0;
        cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
        in0 = '0;   in1 = '0;   in2 = '0;
        cyc(2);
        chk("reset_rd", rd0, 32'h0);
        chk("reset_irq", {31'b0, irq0}, 32'h0);
        reset_n = 1'b1;
        cyc(1);

        // Reset mid-operation with every capture and mask bit set
        in0 = 8'hFF;
        cyc(4);
        wr(0, 2'd2, 32'hFF);
        chk("t1_irq_before", {31'b0, irq0}, 32'h1);
        rd(0, 2'd3, 32'hFF, "t1_ec_before");
        #2;
        reset_n = 1'b0;
        in0     = 8'h00;
        #1;
        chk("t1_async_irq", {31'b0, irq0}, 32'h0);
        chk("t1_async_rd", rd0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(0, 2'd0, 32'h0, "t1_data_after");
        rd(0, 2'd1, 32'h0, "t1_rsvd_after");
        rd(0, 2'd2, 32'h0, "t1_mask_after");
        rd(0, 2'd3, 32'h0, "t1_ec_after");
        chk("t1_irq_after", {31'b0, irq0}, 32'h0);

        // Rising capture, mask enables IRQ, W1C clears it
        in0 = 8'h01;
        cyc(4);
        wr(0, 2'd3, 32'hFF);
        in0 = 8'h03;
        cyc(4);
        rd(0, 2'd3, 32'h02, "t3_ec");
        chk("t3_irq_masked", {31'b0, irq0}, 32'h0);
        wr(0, 2'd2, 32'h02);
        chk("t3_irq_on", {31'b0, irq0}, 32'h1);
        wr(0, 2'd3, 32'h02);
        chk("t3_irq_off", {31'b0, irq0}, 32'h0);
        rd(0, 2'd3, 32'h0, "t3_ec_cleared");

        // New rising edge lands on the same edge as a W1C of that bit
        in0 = 8'h01;
        cyc(4);
        chk("t4_irq_pre", {31'b0, irq0}, 32'h0);
        in0 = 8'h03;
        cyc(2);
        wr(0, 2'd3, 32'h02);
        chk("t4_irq_kept", {31'b0, irq0}, 32'h1);
        rd(0, 2'd3, 32'h02, "t4_ec_kept");

        // Table-driven latency sweep with DEBOUNCE_CYCLES=0
        in0 = 8'h00;
        cyc(4);
        wr(0, 2'd3, 32'hFF);
        wr(0, 2'd2, 32'h0F);
        for (int i = 0; i < 11; i++) begin
            in0     = vec[i].in_val;
            address = vec[i].addr;
            @(negedge clk);
            chk($sformatf("vec%0d_rd", i), rd0, vec[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq0}, {31'b0, vec[i].exp_irq});
        end

        // Debounce: short glitch rejected, long pulse accepted after 4 stable cycles
        wr(1, 2'd2, 32'h01);
        in1 = 8'h01;
        cyc(3);
        in1 = 8'h00;
        cyc(10);
        rd(1, 2'd0, 32'h0, "t5_glitch_data");
        rd(1, 2'd3, 32'h0, "t5_glitch_ec");
        chk("t5_glitch_irq", {31'b0, irq1}, 32'h0);
        in1 = 8'h01;
        cyc(6);
        chk("t5_irq_early", {31'b0, irq1}, 32'h0);
        cyc(1);
        chk("t5_irq_on", {31'b0, irq1}, 32'h1);
        cyc(3);
        in1 = 8'h00;
        rd(1, 2'd0, 32'h1, "t5_data");
        rd(1, 2'd3, 32'h1, "t5_ec");

        // Any-edge capture twice with a clear between, and writes to read-only addresses
        wr(2, 2'd2, 32'h08);
        in2 = 8'h08;
        cyc(4);
        rd(2, 2'd3, 32'h08, "t6_rise_ec");
        wr(2, 2'd3, 32'h08);
        rd(2, 2'd3, 32'h0, "t6_cleared");
        chk("t6_irq_cleared", {31'b0, irq2}, 32'h0);
        in2 = 8'h00;
        cyc(4);
        rd(2, 2'd3, 32'h08, "t6_fall_ec");
        chk("t6_irq_fall", {31'b0, irq2}, 32'h1);
        wr(2, 2'd0, 32'hFFFFFFFF);
        wr(2, 2'd1, 32'hFFFFFFFF);
        rd(2, 2'd2, 32'h08, "t6_mask_unchanged");
        rd(2, 2'd3, 32'h08, "t6_ec_unchanged");
        rd(2, 2'd0, 32'h0, "t6_data_unchanged");
        rd(2, 2'd1, 32'h0, "t6_rsvd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
